// File: rtl/uart_frame_rx_if.sv
// Frame-buffer write port and status pulses from the UART row-record receiver.
// The receiver drives everything; the frame buffer and any status logic only listen.
`timescale 1ns/1ps
interface uart_frame_rx_if;
  logic       wr_en_o;
  logic [2:0] wr_row_o;
  logic [7:0] wr_r_o;
  logic [7:0] wr_g_o;
  logic [7:0] wr_b_o;
  logic       frame_done_o;
  logic       frame_err_o;
  logic       proto_err_o;
  logic       busy_o;

  modport master (
    output wr_en_o, wr_row_o, wr_r_o, wr_g_o, wr_b_o,
    output frame_done_o, frame_err_o, proto_err_o, busy_o
  );
  modport slave (
    input wr_en_o, wr_row_o, wr_r_o, wr_g_o, wr_b_o,
    input frame_done_o, frame_err_o, proto_err_o, busy_o
  );
endinterface

// File: rtl/uart_frame_rx.sv
// 8N1 UART receiver parsing {row, red, green, blue} records into frame-buffer writes;
// the write strobe lands 2 cycles after the blue stop-bit sample; no backpressure, the line is never stalled.
`timescale 1ns/1ps
module uart_frame_rx #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 12
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            rx_i,
  uart_frame_rx_if.master bus
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TO_LIMIT     = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int TW           = $clog2(TO_LIMIT + 1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
  typedef enum logic [1:0] {S_ROW, S_RED, S_GRN, S_BLU} pstate_t;

  logic          r_sync1, r_rxs;
  bstate_t       r_bst;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_stb, r_ferr, r_armed;
  pstate_t       r_pst;
  logic [TW-1:0] r_to;
  logic [2:0]    r_row;
  logic [7:0]    r_red, r_grn;
  logic          w_start, w_timeout;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_rxs   <= r_sync1;
    end
  end

  // After a low stop bit (e.g. a break) the line must go high before a new start is accepted.
  assign w_start   = (r_bst == B_IDLE) && r_armed && !r_rxs;
  assign w_timeout = (r_pst != S_ROW) && (r_bst == B_IDLE) && (r_to == TW'(TO_LIMIT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bst   <= B_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_stb   <= 1'b0;
      r_ferr  <= 1'b0;
      r_armed <= 1'b1;
    end else begin
      r_stb  <= 1'b0;
      r_ferr <= 1'b0;
      case (r_bst)
        B_IDLE: begin
          if (!r_armed) begin
            r_armed <= r_rxs;
          end else if (!r_rxs) begin
            r_bst <= B_START;
            r_cnt <= '0;
          end
        end
        B_START: begin
          if (r_cnt == CW'(HALF_BIT)) begin
            r_cnt <= '0;
            r_bit <= '0;
            r_bst <= r_rxs ? B_IDLE : B_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        B_DATA: begin
          if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
            r_cnt   <= '0;
            r_shift <= {r_rxs, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_bst <= B_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
            r_cnt <= '0;
            r_bst <= B_IDLE;
            if (r_rxs) begin
              r_stb <= 1'b1;
            end else begin
              r_ferr  <= 1'b1;
              r_armed <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pst            <= S_ROW;
      r_to             <= '0;
      r_row            <= '0;
      r_red            <= '0;
      r_grn            <= '0;
      bus.wr_en_o      <= 1'b0;
      bus.wr_row_o     <= '0;
      bus.wr_r_o       <= '0;
      bus.wr_g_o       <= '0;
      bus.wr_b_o       <= '0;
      bus.frame_done_o <= 1'b0;
      bus.frame_err_o  <= 1'b0;
      bus.proto_err_o  <= 1'b0;
    end else begin
      bus.wr_en_o      <= 1'b0;
      bus.frame_done_o <= 1'b0;
      bus.frame_err_o  <= 1'b0;
      bus.proto_err_o  <= 1'b0;
      if (w_start || r_pst == S_ROW) r_to <= '0;
      else if (r_bst == B_IDLE)      r_to <= r_to + TW'(1);

      // Framing error outranks timeout so at most one error pulse fires per cycle.
      if (r_ferr) begin
        bus.frame_err_o <= 1'b1;
        r_pst           <= S_ROW;
      end else if (w_timeout) begin
        bus.proto_err_o <= 1'b1;
        r_pst           <= S_ROW;
      end else if (r_stb) begin
        case (r_pst)
          S_ROW: begin
            if (|r_shift[7:3]) begin
              bus.proto_err_o <= 1'b1;
            end else begin
              r_row <= r_shift[2:0];
              r_pst <= S_RED;
            end
          end
          S_RED: begin
            r_red <= r_shift;
            r_pst <= S_GRN;
          end
          S_GRN: begin
            r_grn <= r_shift;
            r_pst <= S_BLU;
          end
          default: begin
            bus.wr_en_o      <= 1'b1;
            bus.wr_row_o     <= r_row;
            bus.wr_r_o       <= r_red;
            bus.wr_g_o       <= r_grn;
            bus.wr_b_o       <= r_shift;
            bus.frame_done_o <= (r_row == 3'd7);
            r_pst            <= S_ROW;
          end
        endcase
      end
    end
  end

  assign bus.busy_o = (r_bst != B_IDLE) || (r_pst != S_ROW);
endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- Receive side of the LED-matrix host link: deserialises 8N1 UART bytes on `rx_i` and parses them into 4-byte row records (row address, red, green, blue).
- For each good record, issues a one-cycle write strobe to the frame buffer that feeds the row/column scanner.
- Detects framing errors, protocol errors and inter-byte timeouts.
- Resynchronises to record boundaries on any error.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (=434, integer division), clocks per bit period.
- TIMEOUT_BITS, 12, idle bit periods allowed between bytes inside a record.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- rx_i  in  1  UART line, idle high, asynchronous to clk_i.
- wr_en_o  out  1  one-cycle pulse: record complete, write to frame buffer.
- wr_row_o  out  3  row address of the record; valid with wr_en_o.
- wr_r_o  out  8  red column mask; valid with wr_en_o.
- wr_g_o  out  8  green column mask; valid with wr_en_o.
- wr_b_o  out  8  blue column mask; valid with wr_en_o.
- frame_done_o  out  1  one-cycle pulse, coincident with the wr_en_o for row 7.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- proto_err_o  out  1  one-cycle pulse: row byte bits [7:3] non-zero, or inter-byte timeout.
- busy_o  out  1  high while the bit FSM is not IDLE or the parser is not in S_ROW.

Behaviour:
- Reset (async assert, sync deassert via rst_ni):
  - all outputs 0; the 2-flop rx synchroniser presets to 1.
  - bit FSM -> IDLE; parser -> S_ROW; all counters 0.
- Input sync: rx_i passes through 2 flops; all logic uses the synchronised value rxs.
- Bit FSM:
  - IDLE: on rxs==0 go to START and clear the counter.
  - START: at count CLKS_PER_BIT/2 (217), sample rxs.
    - 1: glitch, return to IDLE, no strobe.
    - 0: go to DATA, counter 0.
  - DATA: sample every CLKS_PER_BIT clocks, LSB first, 8 bits, then go to STOP.
  - STOP: sample after CLKS_PER_BIT clocks, then return to IDLE the next cycle. A new start bit can therefore be detected from the second half of the stop bit onward.
    - 1: byte strobe (internal, one cycle).
    - 0: frame_err_o pulses one cycle later, no byte strobe.
- Parser, advanced by the byte strobe: S_ROW -> S_RED -> S_GRN -> S_BLU -> S_ROW.
  - S_ROW: byte[7:3]!=0 -> proto_err_o pulse, stay in S_ROW, byte discarded. Otherwise latch byte[2:0] and go to S_RED.
  - S_RED, S_GRN: latch the byte into the red / green register.
  - S_BLU: on the cycle after the blue byte strobe:
    - wr_en_o=1 for one cycle;
    - wr_row_o/wr_r_o/wr_g_o/wr_b_o present the record (blue taken from the strobe byte);
    - frame_done_o=1 in the same cycle iff row==7.
  - wr_* data outputs hold their values until the next write.
- Framing error: frame_err_o pulses and the parser forces S_ROW (partial record dropped). This applies in any parser state.
- Timeout:
  - A counter runs while the parser is not in S_ROW and the bit FSM is IDLE.
  - It clears on every start detect.
  - On reaching TIMEOUT_BITS*CLKS_PER_BIT: proto_err_o pulses and the parser goes to S_ROW.
- Simultaneous events: a framing error has priority over a timeout in the same cycle; at most one error pulse per cycle.
- Rows may arrive in any order; duplicate rows are written again; frame_done_o keys only on row 7.
- Line held low (break): the byte reads 0x00 with the stop bit low, giving a framing error. The FSM stays IDLE until rxs returns high, then re-arms.
- Reset mid-byte: everything aborts immediately; no strobe is emitted for the interrupted byte.

Test Plan:
- Reset, line idle, send bytes 0x03,0xFF,0x00,0xFF at 8680 ns/bit -> exactly one wr_en_o, wr_row_o=3, wr_r_o=FF, wr_g_o=00, wr_b_o=FF; frame_done_o=0.
- Send 8 records, rows 0..7, each FF/00/FF -> 8 wr_en_o pulses with rows in order; frame_done_o pulses once, coincident with row 7.
- Send 0x02, 0x11, then 0x22 with stop bit forced 0 -> frame_err_o pulses once, no write. Then send 0x05,0xAA,0x55,0x0F -> write row=5, r=AA, g=55, b=0F.
- Send row byte 0x09 -> proto_err_o pulse, no write. Then send 0x01,0x80,0x40,0x20 -> write row=1, r=80, g=40, b=20.
- Send 0x04, 0x12, then idle 13 bit periods -> proto_err_o pulse at 12*434 clocks after the last stop sample. Then send 0x06,0x01,0x02,0x03 -> write row=6, r=01, g=02, b=03.
- Drive rx_i low for 100 ns, then high -> no strobe, no error, busy_o back to 0 within CLKS_PER_BIT/2+3 cycles.
- Assert rst_ni during the DATA bits of a green byte -> all outputs 0 immediately. After release, a fresh 4-byte record is written correctly.
